// File: rtl/int_seq_pkg.sv
// Shared types and constants for the 6502 interrupt/reset entry sequencer:
// sequence kinds, vector low bytes, microsequence cycle indices and a helper
// that turns (active, cycle, kind) into the registered output bundle.
package int_seq_pkg;

    typedef enum logic [1:0] {
        KIND_RES,
        KIND_NMI,
        KIND_IRQ,
        KIND_BRK
    } kind_e;

    localparam logic [7:0] VEC_NMI_LO = 8'hFA;
    localparam logic [7:0] VEC_RES_LO = 8'hFC;
    localparam logic [7:0] VEC_IRQ_LO = 8'hFE;

    localparam logic [2:0] CYC_FETCH = 3'd0;
    localparam logic [2:0] CYC_DUMMY = 3'd1;
    localparam logic [2:0] CYC_PCH   = 3'd2;
    localparam logic [2:0] CYC_PCL   = 3'd3;
    localparam logic [2:0] CYC_P     = 3'd4;
    localparam logic [2:0] CYC_VL    = 3'd5;
    localparam logic [2:0] CYC_VH    = 3'd6;

    typedef struct packed {
        logic       int_force;
        logic       pc_hold;
        logic       seq_act;
        logic [2:0] seq_cyc;
        logic       wr_suppress;
        logic       b_flag;
        logic       set_i;
        logic       brk5;
        logic       brk6e;
        logic [7:0] vec_adl;
        logic       nmi_ack;
    } seq_out_t;

    // Vector low byte for a sequence kind (BRK shares the IRQ vector).
    function automatic logic [7:0] vec_lo(kind_e kind);
        logic [7:0] lo;
        lo = VEC_IRQ_LO;
        case (kind)
            KIND_RES: lo = VEC_RES_LO;
            KIND_NMI: lo = VEC_NMI_LO;
            default:  lo = VEC_IRQ_LO;
        endcase
        return lo;
    endfunction

    // Output bundle for the cycle the sequencer is about to enter.
    function automatic seq_out_t seq_outputs(logic act, logic [2:0] cyc, kind_e kind);
        seq_out_t o;
        logic     push;
        o    = '0;
        push = (cyc >= CYC_PCH) && (cyc <= CYC_P);
        if (act) begin
            o.seq_act     = 1'b1;
            o.seq_cyc     = cyc;
            o.int_force   = (cyc == CYC_FETCH);
            // BRK enters at the dummy cycle with PC advancing past the signature byte.
            o.pc_hold     = (cyc == CYC_FETCH) || ((cyc == CYC_DUMMY) && (kind != KIND_BRK));
            o.wr_suppress = push && (kind == KIND_RES);
            o.b_flag      = push && (kind == KIND_BRK);
            o.set_i       = (cyc == CYC_VL);
            o.brk5        = (cyc == CYC_VL);
            o.brk6e       = (cyc == CYC_VH);
            o.nmi_ack     = (cyc == CYC_VL) && (kind == KIND_NMI);
            if (cyc == CYC_VL) o.vec_adl = vec_lo(kind);
            if (cyc == CYC_VH) o.vec_adl = vec_lo(kind) | 8'h01;
        end
        return o;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi.sv
// NMI front end: two-flop synchronizer on the active-low NMI pin, falling
// edge detection on the synchronized signal, and the pending flag. A set
// and a clear in the same cycle leave the flag set so no edge is lost.
module nmi_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic nmi_n,
    input  logic clr,
    output logic nmi_pend
);

    logic nmi_s1;
    logic nmi_s2;
    logic nmi_s2_d;

    // Synchronize, delay once more for edge detection, and track pending state.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            nmi_s1   <= 1'b1;
            nmi_s2   <= 1'b1;
            nmi_s2_d <= 1'b1;
            nmi_pend <= 1'b0;
        end else begin
            nmi_s1   <= nmi_n;
            nmi_s2   <= nmi_s1;
            nmi_s2_d <= nmi_s2;
            if (nmi_s2_d && !nmi_s2) begin
                nmi_pend <= 1'b1;
            end else if (clr) begin
                nmi_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/reset entry sequencer. Runs RES, NMI, IRQ and BRK through
// one shared 7-cycle microsequence (BRK joins at cycle 1) and drives the
// registered control markers for the random-control logic.
// Optional feature: define NMI_HIJACK_EN to let an NMI arriving during an
// IRQ/BRK push phase take over the vector fetch of that sequence.
module interrupt_sequencer
    import int_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       i_flag,
    input  logic       rdy,
    input  logic       t0,
    input  logic       brk_op,
    output logic       int_force,
    output logic       pc_hold,
    output logic       seq_act,
    output logic [2:0] seq_cyc,
    output logic       wr_suppress,
    output logic       b_flag,
    output logic       set_i,
    output logic       brk5,
    output logic       brk6e,
    output logic [7:0] vec_adl,
    output logic       nmi_ack
);

    logic       act_q;
    logic [2:0] cyc_q;
    kind_e      kind_q;
    logic       res_pend_q;
    logic       irq_s1;
    logic       irq_s2;
    seq_out_t   out_q;

    logic       nxt_act;
    logic [2:0] nxt_cyc;
    kind_e      nxt_kind;
    logic       nxt_res_pend;
    logic       nmi_clr;
    logic       nmi_pend;
    logic       irq_pend;
    logic       hw_pend;
    logic       advance;

    nmi_edge_detect u_nmi (
        .clk      (clk),
        .reset    (reset),
        .nmi_n    (nmi_n),
        .clr      (nmi_clr),
        .nmi_pend (nmi_pend)
    );

    assign irq_pend = !irq_s2 && !i_flag;
    assign hw_pend  = nmi_pend || irq_pend;

    // Next-state decision: start, advance or stall the microsequence.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        nxt_act      = act_q;
        nxt_cyc      = cyc_q;
        nxt_kind     = kind_q;
        nxt_res_pend = res_pend_q;
        nmi_clr      = 1'b0;
        // Push cycles of non-reset sequences are writes and ignore RDY.
        advance      = rdy || ((kind_q != KIND_RES) && (cyc_q >= CYC_PCH) && (cyc_q <= CYC_P));

        if (!act_q) begin
            if (res_pend_q) begin
                nxt_act      = 1'b1;
                nxt_cyc      = CYC_FETCH;
                nxt_kind     = KIND_RES;
                nxt_res_pend = 1'b0;
            end else if (t0 && rdy && hw_pend) begin
                nxt_act  = 1'b1;
                nxt_cyc  = CYC_FETCH;
                nxt_kind = nmi_pend ? KIND_NMI : KIND_IRQ;
            end else if (brk_op && !hw_pend) begin
                nxt_act  = 1'b1;
                nxt_cyc  = CYC_DUMMY;
                nxt_kind = KIND_BRK;
            end
        end else if (advance) begin
            if (cyc_q == CYC_VH) begin
                nxt_act = 1'b0;
                nxt_cyc = CYC_FETCH;
            end else begin
                nxt_cyc = cyc_q + 3'd1;
                if (cyc_q == CYC_P) begin
`ifdef NMI_HIJACK_EN
                    if (nmi_pend && ((kind_q == KIND_IRQ) || (kind_q == KIND_BRK))) begin
                        nxt_kind = KIND_NMI;
                    end
`endif
                    nmi_clr = (nxt_kind == KIND_NMI) || (nxt_kind == KIND_RES);
                end
            end
        end
    end

    // State, IRQ synchronizer and registered outputs for the upcoming cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q      <= 1'b0;
            cyc_q      <= CYC_FETCH;
            kind_q     <= KIND_RES;
            res_pend_q <= 1'b1;
            irq_s1     <= 1'b1;
            irq_s2     <= 1'b1;
            out_q      <= '0;
        end else begin
            act_q      <= nxt_act;
            cyc_q      <= nxt_cyc;
            kind_q     <= nxt_kind;
            res_pend_q <= nxt_res_pend;
            irq_s1     <= irq_n;
            irq_s2     <= irq_s1;
            out_q      <= seq_outputs(nxt_act, nxt_cyc, nxt_kind);
        end
    end

    assign int_force   = out_q.int_force;
    assign pc_hold     = out_q.pc_hold;
    assign seq_act     = out_q.seq_act;
    assign seq_cyc     = out_q.seq_cyc;
    assign wr_suppress = out_q.wr_suppress;
    assign b_flag      = out_q.b_flag;
    assign set_i       = out_q.set_i;
    assign brk5        = out_q.brk5;
    assign brk6e       = out_q.brk6e;
    assign vec_adl     = out_q.vec_adl;
    assign nmi_ack     = out_q.nmi_ack;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer. Outputs are packed into one
// 20-bit word {act, cyc, force, hold, wrs, b, seti, brk5, brk6e, ack, vec}
// and compared against hand-derived words one cycle at a time.
module tb_interrupt_sequencer;

    logic       clk = 1'b0;
    logic       reset, nmi_n, irq_n, i_flag, rdy, t0, brk_op;
    logic       int_force, pc_hold, seq_act, wr_suppress, b_flag, set_i;
    logic       brk5, brk6e, nmi_ack;
    logic [2:0] seq_cyc;
    logic [7:0] vec_adl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    interrupt_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .nmi_n       (nmi_n),
        .irq_n       (irq_n),
        .i_flag      (i_flag),
        .rdy         (rdy),
        .t0          (t0),
        .brk_op      (brk_op),
        .int_force   (int_force),
        .pc_hold     (pc_hold),
        .seq_act     (seq_act),
        .seq_cyc     (seq_cyc),
        .wr_suppress (wr_suppress),
        .b_flag      (b_flag),
        .set_i       (set_i),
        .brk5        (brk5),
        .brk6e       (brk6e),
        .vec_adl     (vec_adl),
        .nmi_ack     (nmi_ack)
    );

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] obs();
        return {seq_act, seq_cyc, int_force, pc_hold, wr_suppress, b_flag,
                set_i, brk5, brk6e, nmi_ack, vec_adl};
    endfunction

    function automatic logic [19:0] ev(input bit act, input logic [2:0] cyc,
                                       input bit f, input bit h, input bit w,
                                       input bit b, input bit si, input bit b5,
                                       input bit b6, input bit ack, input logic [7:0] v);
        return {act, cyc, f, h, w, b, si, b5, b6, ack, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [19:0] exp);
        tick();
        check(tag, obs(), exp);
    endtask

    // Caller has just clocked into cycle 'first'; walk to cycle 6 then idle.
    task automatic run_seq(input string tag, input int first, input bit hold1,
                           input bit wrs, input bit b, input logic [7:0] lo, input bit ack);
        for (int c = first; c <= 6; c++) begin
            logic [7:0] v;
            bit         push;
            if (c != first) tick();
            push = (c >= 2) && (c <= 4);
            v    = (c == 5) ? lo : ((c == 6) ? (lo | 8'h01) : 8'h00);
            check($sformatf("%s_c%0d", tag, c), obs(),
                  ev(1'b1, 3'(c), c == 0, (c == 0) || (c == 1 && hold1),
                     wrs && push, b && push, c == 5, c == 5, c == 6,
                     ack && (c == 5), v));
        end
        step({tag, "_idle"}, 20'h0);
    endtask

    initial begin
        reset = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;
        rdy = 1'b1; t0 = 1'b0; brk_op = 1'b0;

        // Power-on reset sequence.
        tick(); tick(); tick();
        check("reset_vals", obs(), 20'h0);
        reset = 1'b0;
        tick();
        run_seq("res", 0, 1'b1, 1'b1, 1'b0, 8'hFC, 1'b0);

        // NMI: first sampled low at edge k, T0 during the cycle after k+3.
        nmi_n = 1'b0;
        tick(); tick(); tick(); tick();
        check("nmi_wait", obs(), 20'h0);
        t0 = 1'b1;
        tick();
        t0 = 1'b0; nmi_n = 1'b1;
        run_seq("nmi", 0, 1'b1, 1'b0, 1'b0, 8'hFA, 1'b1);
        t0 = 1'b1;
        step("nmi_cleared", 20'h0);
        t0 = 1'b0;

        // IRQ masked, then unmasked.
        irq_n = 1'b0;
        tick(); tick(); tick();
        t0 = 1'b1;
        step("irq_masked", 20'h0);
        i_flag = 1'b0;
        tick();
        t0 = 1'b0;
        run_seq("irq", 0, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b0);
        irq_n = 1'b1; i_flag = 1'b1;
        tick(); tick();

        // Software BRK joins at cycle 1.
        brk_op = 1'b1;
        tick();
        brk_op = 1'b0;
        run_seq("brk", 1, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0);

        // NMI edge during the push phase of an IRQ sequence.
        irq_n = 1'b0; i_flag = 1'b0;
        tick(); tick(); tick();
        t0 = 1'b1;
        tick();
        t0 = 1'b0; irq_n = 1'b1; i_flag = 1'b1; nmi_n = 1'b0;
`ifdef NMI_HIJACK_EN
        run_seq("hijack", 0, 1'b1, 1'b0, 1'b0, 8'hFA, 1'b1);
        nmi_n = 1'b1; t0 = 1'b1;
        step("hijack_no_rerun", 20'h0);
        t0 = 1'b0;
`else
        run_seq("nohijack", 0, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b0);
        nmi_n = 1'b1; t0 = 1'b1;
        tick();
        t0 = 1'b0;
        run_seq("nmi_late", 0, 1'b1, 1'b0, 1'b0, 8'hFA, 1'b1);
`endif

        // RDY: ignored in a push cycle, stalls the vector-low cycle.
        irq_n = 1'b0; i_flag = 1'b0;
        tick(); tick(); tick();
        t0 = 1'b1;
        tick();
        t0 = 1'b0; irq_n = 1'b1; i_flag = 1'b1;
        check("stl_c0", obs(), ev(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        step("stl_c1", ev(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        step("stl_c2", ev(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        step("stl_c3", ev(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        rdy = 1'b0;
        step("stl_nostall_c4", ev(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        rdy = 1'b1;
        step("stl_c5a", ev(1, 5, 0, 0, 0, 0, 1, 1, 0, 0, 8'hFE));
        rdy = 1'b0;
        step("stl_c5b", ev(1, 5, 0, 0, 0, 0, 1, 1, 0, 0, 8'hFE));
        step("stl_c5c", ev(1, 5, 0, 0, 0, 0, 1, 1, 0, 0, 8'hFE));
        rdy = 1'b1;
        step("stl_c6", ev(1, 6, 0, 0, 0, 0, 0, 0, 1, 0, 8'hFF));
        step("stl_idle", 20'h0);

        // Reset stalls on RDY in push cycles, then is aborted mid-sequence.
        reset = 1'b1;
        step("reset2_vals", 20'h0);
        reset = 1'b0;
        step("rs_c0", ev(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        step("rs_c1", ev(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        step("rs_c2", ev(1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00));
        step("rs_c3", ev(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00));
        rdy = 1'b0;
        step("rs_stall_c3", ev(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00));
        rdy = 1'b1;
        step("rs_c4", ev(1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00));
        reset = 1'b1;
        step("rs_abort", 20'h0);
        reset = 1'b0;
        tick();
        run_seq("res2", 0, 1'b1, 1'b1, 1'b0, 8'hFC, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
